// File: rtl/wb_byte_master_pkg.sv
// wb_byte_master_pkg: shared encodings for the byte-stream Wishbone initiator and its peripherals
package wb_byte_master_pkg;
  typedef enum logic [1:0] {IDLE, GET_DATA, BUS, RESP} state_e;
  localparam int BYTE_W = 8;
  localparam int CMD_WE_BIT = 7;
  localparam logic [7:0] TIMEOUT_RESP_BYTE = 8'h00;
  localparam logic [3:0] REG_STATUS = 4'h0;
  localparam logic [3:0] REG_WIDTH  = 4'h1;
  localparam logic [3:0] REG_DLY_LO = 4'h2;
  localparam logic [3:0] REG_DLY_HI = 4'h3;
endpackage

// File: rtl/wb_byte_master_if.sv
// wb_byte_master_if: command/response byte streams plus the Wishbone single-transfer bus
interface wb_byte_master_if import wb_byte_master_pkg::*; #(parameter int ADR_W = 4);
  logic [BYTE_W-1:0] cmd_data_i;
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [BYTE_W-1:0] rsp_data_o;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic              cyc_o;
  logic              stb_o;
  logic              we_o;
  logic [ADR_W-1:0]  adr_o;
  logic [BYTE_W-1:0] dat_o;
  logic [BYTE_W-1:0] dat_i;
  logic              ack_i;
  modport master (
    input  cmd_data_i, cmd_valid_i, rsp_ready_i, dat_i, ack_i,
    output cmd_ready_o, rsp_data_o, rsp_valid_o, cyc_o, stb_o, we_o, adr_o, dat_o
  );
  modport slave (
    output cmd_data_i, cmd_valid_i, rsp_ready_i, dat_i, ack_i,
    input  cmd_ready_o, rsp_data_o, rsp_valid_o, cyc_o, stb_o, we_o, adr_o, dat_o
  );
endinterface

// File: rtl/wb_timeout_ctr.sv
// wb_timeout_ctr: clear/enable cycle counter flagging the TIMEOUT-th enabled cycle (0 disables)
module wb_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = clr_i ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
  assign tc_o = (TIMEOUT != 0) && en_i && (cnt_q == LAST);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/wb_byte_master.sv
// wb_byte_master: byte-command driven Wishbone single-transfer initiator with response stream
// and an optional strobe timeout.
module wb_byte_master import wb_byte_master_pkg::*; #(
  parameter int ADR_W   = 4,
  parameter int DAT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  wb_byte_master_if.master   bus,
  output logic               busy_o,
  output logic               err_o
);
  state_e state_q, state_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [DAT_W-1:0] dat_q, dat_d, rsp_q, rsp_d;
  logic we_q, we_d, stb_q, stb_d, err_q, err_d, ack, tc;
  // ack only counts while our own strobe is up; late echoes from the responder fall outside it
  assign ack = stb_q & bus.ack_i;
  wb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(!stb_q || ack), .en_i(stb_q), .tc_o(tc)
  );
  always_comb begin
    state_d = state_q;
    adr_d = adr_q;
    we_d = we_q;
    dat_d = dat_q;
    rsp_d = rsp_q;
    stb_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (bus.cmd_valid_i) begin
        adr_d = bus.cmd_data_i[ADR_W-1:0];
        we_d = bus.cmd_data_i[CMD_WE_BIT];
        state_d = bus.cmd_data_i[CMD_WE_BIT] ? GET_DATA : BUS;
      end
      GET_DATA: if (bus.cmd_valid_i) begin
        dat_d = bus.cmd_data_i;
        state_d = BUS;
      end
      BUS: if (ack) begin
        rsp_d = we_q ? rsp_q : bus.dat_i;
        state_d = we_q ? IDLE : RESP;
      end else if (tc) begin
        err_d = 1'b1;
        rsp_d = we_q ? rsp_q : TIMEOUT_RESP_BYTE;
        state_d = we_q ? IDLE : RESP;
      end else stb_d = 1'b1;
      RESP: state_d = bus.rsp_ready_i ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      adr_q <= '0;
      we_q <= 1'b0;
      dat_q <= '0;
      rsp_q <= '0;
      stb_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q <= adr_d;
      we_q <= we_d;
      dat_q <= dat_d;
      rsp_q <= rsp_d;
      stb_q <= stb_d;
      err_q <= err_d;
    end
  assign bus.cyc_o = stb_q;
  assign bus.stb_o = stb_q;
  assign bus.we_o = we_q;
  assign bus.adr_o = adr_q;
  assign bus.dat_o = dat_q;
  assign bus.rsp_data_o = rsp_q;
  assign bus.rsp_valid_o = state_q == RESP;
  assign bus.cmd_ready_o = rst_ni && (state_q == IDLE || state_q == GET_DATA);
  assign busy_o = state_q != IDLE;
  assign err_o = err_q;
endmodule

// File: tb/tb_wb_byte_master.sv
// tb_wb_byte_master: directed scoreboard bench with a registered-ack responder model
module tb_wb_byte_master;
  import wb_byte_master_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, err;
  logic resp_en = 1'b1;
  logic [7:0] rmem [16];
  int errors = 0;
  int checks = 0;
  logic [12:0] xfer_q[$], exp_x[$];
  int len_q[$], exp_len[$];
  logic [7:0] rsp_exp[$];
  int run = 0, gap = 100, last_gap = 0;
  int rsp_rises = 0, exp_rises = 0, err_cyc = 0, exp_err = 0;
  logic rsp_prev = 1'b0;

  wb_byte_master_if #(.ADR_W(4)) bus();
  wb_byte_master #(.ADR_W(4), .DAT_W(8), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.ack_i <= 1'b0;
      bus.dat_i <= 8'h00;
    end else begin
      bus.ack_i <= resp_en && bus.cyc_o && bus.stb_o;
      bus.dat_i <= rmem[bus.adr_o];
    end

  always @(negedge clk) begin
    if (bus.stb_o) begin
      if (run == 0) begin
        xfer_q.push_back(bus.we_o ? {1'b1, bus.adr_o, bus.dat_o} : {1'b0, bus.adr_o, 8'h00});
        last_gap = gap;
      end
      run++;
      gap = 0;
    end else begin
      if (run > 0) len_q.push_back(run);
      run = 0;
      gap++;
    end
    if (bus.rsp_valid_o && !rsp_prev) rsp_rises++;
    rsp_prev = bus.rsp_valid_o;
    if (err) err_cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!bus.cmd_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready", bus.cmd_ready_o, 1);
    bus.cmd_data_i = b;
    bus.cmd_valid_i = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid_i = 1'b0;
  endtask

  task automatic get_rsp();
    int n = 0;
    logic [7:0] e = 8'h00;
    while (!bus.rsp_valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_valid", bus.rsp_valid_o, 1);
    chk("rsp_pending", rsp_exp.size() > 0, 1);
    if (rsp_exp.size() > 0) e = rsp_exp.pop_front();
    chk("rsp_data", bus.rsp_data_o, e);
    bus.rsp_ready_i = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready_i = 1'b0;
    @(negedge clk);
    chk("rsp_drop", bus.rsp_valid_o, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle", busy, 0);
    @(negedge clk);
  endtask

  task automatic drain();
    chk("n_xfer", xfer_q.size(), exp_x.size());
    chk("n_stb_len", len_q.size(), exp_len.size());
    while (exp_x.size() > 0 && xfer_q.size() > 0) chk("xfer", xfer_q.pop_front(), exp_x.pop_front());
    while (exp_len.size() > 0 && len_q.size() > 0) chk("stb_len", len_q.pop_front(), exp_len.pop_front());
    exp_x.delete();
    xfer_q.delete();
    exp_len.delete();
    len_q.delete();
    chk("rsp_rises", rsp_rises, exp_rises);
    chk("err_cycles", err_cyc, exp_err);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    exp_x.push_back({1'b1, a, d});
    exp_len.push_back(2);
    send({4'h8, a});
    send(d);
    wait_idle();
    drain();
  endtask

  task automatic rd(input logic [3:0] a);
    exp_x.push_back({1'b0, a, 8'h00});
    exp_len.push_back(resp_en ? 2 : 8);
    rsp_exp.push_back(resp_en ? rmem[a] : TIMEOUT_RESP_BYTE);
    exp_rises++;
    if (!resp_en) exp_err++;
    send({4'h0, a});
    get_rsp();
    wait_idle();
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 16; i++) rmem[i] = 8'(i * 7 + 1);
    rmem[REG_STATUS] = 8'h11;
    rmem[REG_WIDTH]  = 8'hC3;
    rmem[REG_DLY_LO] = 8'hA5;
    rmem[REG_DLY_HI] = 8'h5A;
    bus.cmd_data_i = 8'h00;
    bus.cmd_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cyc", bus.cyc_o, 0);
    chk("rst_stb", bus.stb_o, 0);
    chk("rst_we", bus.we_o, 0);
    chk("rst_adr", bus.adr_o, 0);
    chk("rst_dat", bus.dat_o, 0);
    chk("rst_rsp_valid", bus.rsp_valid_o, 0);
    chk("rst_rsp_data", bus.rsp_data_o, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", bus.cmd_ready_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", bus.cmd_ready_o, 1);

    wr(4'h1, 8'h3C);

    exp_x.push_back({1'b0, 4'h2, 8'h00});
    exp_len.push_back(2);
    rsp_exp.push_back(8'hA5);
    exp_rises++;
    send(8'h02);
    @(negedge clk);
    chk("rd_stb_first", bus.stb_o, 0);
    @(negedge clk);
    chk("rd_stb", bus.stb_o, 1);
    chk("rd_cyc", bus.cyc_o, 1);
    chk("rd_we", bus.we_o, 0);
    chk("rd_adr", bus.adr_o, 2);
    chk("rd_cmd_ready_bus", bus.cmd_ready_o, 0);
    chk("rd_busy", busy, 1);
    @(negedge clk);
    chk("rd_valid_early", bus.rsp_valid_o, 0);
    @(negedge clk);
    chk("rd_valid_n3", bus.rsp_valid_o, 1);
    chk("rd_stb_dropped", bus.stb_o, 0);
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", bus.rsp_valid_o, 1);
      chk("hold_data", bus.rsp_data_o, 8'hA5);
      chk("hold_cmd_ready", bus.cmd_ready_o, 0);
    end
    get_rsp();
    wait_idle();
    drain();

    resp_en = 1'b0;
    rd(4'h5);
    resp_en = 1'b1;
    wr(4'h3, 8'h12);

    exp_x.push_back({1'b0, 4'h2, 8'h00});
    exp_x.push_back({1'b0, 4'h3, 8'h00});
    exp_len.push_back(2);
    exp_len.push_back(2);
    rsp_exp.push_back(8'hA5);
    rsp_exp.push_back(8'h5A);
    exp_rises += 2;
    send(8'h02);
    get_rsp();
    send(8'h03);
    get_rsp();
    wait_idle();
    drain();
    chk("b2b_gap", last_gap >= 1, 1);

    exp_x.push_back({1'b1, 4'h0, 8'h77});
    exp_len.push_back(2);
    send(8'h80);
    repeat (20) begin
      @(negedge clk);
      chk("delay_stb", bus.stb_o, 0);
    end
    chk("delay_busy", busy, 1);
    chk("delay_ready", bus.cmd_ready_o, 1);
    send(8'h77);
    wait_idle();
    drain();

    exp_x.push_back({1'b0, 4'h1, 8'h00});
    exp_len.push_back(3);
    resp_en = 1'b0;
    send(8'h01);
    n = 0;
    while (!bus.stb_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_stb", bus.stb_o, 1);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_stb", bus.stb_o, 0);
    chk("async_cyc", bus.cyc_o, 0);
    @(negedge clk);
    chk("rst_mid_valid", bus.rsp_valid_o, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", bus.cmd_ready_o, 0);
    resp_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", bus.cmd_ready_o, 1);
    drain();
    rd(4'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
